key_round_buffer: RTL and testbench

KEY_ROUND_BUFFER -- requirements
Module: key_round_buffer

---
 rtl/key_round_buffer.sv | 124 ++++++++++++
 tb/tb_key_round_buffer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_round_buffer.sv
// Round-key buffer: drives an external key generator through NROUNDS+1 steps,
// stores each round key in its slot, then serves registered slot reads.
module key_round_buffer #(
    parameter int NROUNDS = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    output logic        kg_select,
    output logic        kg_enable_,
    input  logic [63:0] kg_round_key,
    input  logic        rd_en,
    input  logic [3:0]  rd_idx,
    output logic [63:0] rd_key,
    output logic        rd_valid,
    output logic        rd_err,
    output logic        busy,
    output logic        ready,
    output logic        done
);

    localparam int KW = (NROUNDS < 1) ? 1 : $clog2(NROUNDS + 1);
    localparam logic [KW-1:0] K_LAST  = KW'(NROUNDS);
    localparam logic [4:0]    IDX_MAX = 5'(NROUNDS);

    typedef enum logic [1:0] {IDLE, GEN, READY} state_t;

    state_t          state, state_n;
    logic [KW-1:0]   k, k_n;
    logic [63:0]     slot [NROUNDS+1];

    logic            done_p1;
    logic            vld_p1;
    logic            err_p1;
    logic [63:0]     rd_key_p1;
    logic            rd_ok_p0;

    // Control: state and slot counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            k       <= '0;
            done_p1 <= 1'b0;
        end else begin
            state   <= state_n;
            k       <= k_n;
            done_p1 <= (state == GEN) && (k == K_LAST);
        end
    end

    always_comb begin
        state_n    = state;
        k_n        = k;
        kg_select  = 1'b0;
        kg_enable_ = 1'b1;
        busy       = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = GEN;
                    k_n     = '0;
                end
            end
            GEN: begin
                busy       = 1'b1;
                kg_select  = (k != '0);
                // Holding the generator on its last step also reloads its round constant.
                kg_enable_ = (k == K_LAST);
                if (k == K_LAST) begin
                    state_n = READY;
                    k_n     = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            READY: begin
                ready = 1'b1;
                if (start) begin
                    state_n = GEN;
                    k_n     = '0;
                end
            end
            default: begin
                state_n = IDLE;
                k_n     = '0;
            end
        endcase
    end

    // Slot storage, written one slot per GEN cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i <= NROUNDS; i++) begin
                slot[i] <= 64'h0;
            end
        end else if (state == GEN) begin
            slot[k] <= kg_round_key;
        end
    end

    assign rd_ok_p0 = rd_en && (state == READY) && ({1'b0, rd_idx} <= IDX_MAX);

    // Read stage p0 -> p1
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1    <= 1'b0;
            err_p1    <= 1'b0;
            rd_key_p1 <= 64'h0;
        end else begin
            vld_p1 <= rd_ok_p0;
            err_p1 <= rd_en && !rd_ok_p0;
            if (rd_ok_p0) begin
                rd_key_p1 <= slot[rd_idx];
            end
        end
    end

    assign rd_key   = rd_key_p1;
    assign rd_valid = vld_p1;
    assign rd_err   = err_p1;
    assign done     = done_p1;

endmodule

// File: tb/tb_key_round_buffer.sv
// Bench for key_round_buffer: models a rotate/xor key generator and scoreboards
// round-key captures and slot reads against keys from the generator model.
module tb_key_round_buffer;

    localparam int NR = 10;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        kg_select;
    logic        kg_enable_;
    logic [63:0] kg_round_key;
    logic        rd_en;
    logic [3:0]  rd_idx;
    logic [63:0] rd_key;
    logic        rd_valid;
    logic        rd_err;
    logic        busy;
    logic        ready;
    logic        done;

    key_round_buffer #(.NROUNDS(NR)) dut (
        .CLK(CLK), .RST(RST), .start(start),
        .kg_select(kg_select), .kg_enable_(kg_enable_), .kg_round_key(kg_round_key),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_key(rd_key), .rd_valid(rd_valid),
        .rd_err(rd_err), .busy(busy), .ready(ready), .done(done)
    );

    always #5 CLK = ~CLK;

    // Key generator model: hi' = rotl(hi,24) ^ rc, lo' = lo ^ hi'
    function automatic logic [63:0] kstep(input logic [63:0] x, input logic [31:0] r);
        logic [31:0] nh;
        nh = {x[39:32], x[63:40]} ^ r;
        return {nh, x[31:0] ^ nh};
    endfunction

    logic [63:0] cipher_key = 64'h0;
    logic [63:0] g  = 64'h0;
    logic [31:0] rc = 32'd1;
    assign kg_round_key = kg_select ? g : cipher_key;

    always @(posedge CLK) begin
        if (!kg_enable_) begin
            g  <= kstep(kg_round_key, rc);
            rc <= rc + 32'd1;
        end else begin
            rc <= 32'd1;
        end
    end

    logic [63:0] caps[$];
    always @(posedge CLK) begin
        if (RST) caps.delete();
        else if (busy) caps.push_back(kg_round_key);
    end

    typedef struct packed { logic v; logic e; logic [63:0] k; } exp_t;
    exp_t        sb[$];
    exp_t        e;
    logic [63:0] exp_slot [NR+1];
    logic [63:0] last_key = 64'h0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1; start = 1'b0; rd_en = 1'b0; rd_idx = 4'd0;
        tick; tick;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
        n_chk++; if (ready !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", ready); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else n_pass++;
        n_chk++; if (rd_valid !== 1'b0 || rd_err !== 1'b0) $display("FAIL reset_rdflags got=%0b%0b exp=00", rd_valid, rd_err); else n_pass++;
        n_chk++; if (rd_key !== 64'h0) $display("FAIL reset_rdkey got=%h exp=0", rd_key); else n_pass++;
        n_chk++; if (kg_select !== 1'b0 || kg_enable_ !== 1'b1) $display("FAIL reset_kg got=%0b%0b exp=01", kg_select, kg_enable_); else n_pass++;
        RST = 1'b0;
        last_key = 64'h0;
    endtask

    task automatic test_expand(input logic [63:0] ck, input bit hold, input bit rd_in_gen, input bit restart_read);
        int i;
        int dones;
        int bad;
        cipher_key = ck;
        start = 1'b1;
        if (restart_read) begin
            rd_en = 1'b1; rd_idx = 4'd1;
            sb.push_back('{1'b1, 1'b0, exp_slot[1]});
        end
        tick;
        if (restart_read) begin
            e = sb.pop_front();
            n_chk++; if (rd_valid !== e.v || rd_key !== e.k) $display("FAIL restart_read got=%0b/%h exp=%0b/%h", rd_valid, rd_key, e.v, e.k); else n_pass++;
            n_chk++; if (ready !== 1'b0) $display("FAIL restart_ready got=%0b exp=0", ready); else n_pass++;
            last_key = e.k;
            rd_en = 1'b0;
        end
        exp_slot[0] = ck;
        for (int j = 1; j <= NR; j++) exp_slot[j] = kstep(exp_slot[j-1], 32'(j));
        if (!hold) start = 1'b0;
        i = 0; dones = 0;
        while (busy === 1'b1 && i < 40) begin
            n_chk++; if (kg_select !== (i != 0) || kg_enable_ !== (i == NR))
                $display("FAIL gen_kg cyc=%0d got=%0b%0b exp=%0b%0b", i, kg_select, kg_enable_, i != 0, i == NR); else n_pass++;
            if (rd_in_gen) begin
                rd_en = 1'b1; rd_idx = 4'(i);
                sb.push_back('{1'b0, 1'b1, last_key});
            end
            if (i == NR) start = 1'b0;
            tick;
            i++;
            if (done === 1'b1) dones++;
            if (rd_in_gen) begin
                e = sb.pop_front();
                n_chk++; if (rd_err !== e.e || rd_valid !== e.v || rd_key !== e.k)
                    $display("FAIL gen_read got=%0b%0b/%h exp=%0b%0b/%h", rd_err, rd_valid, rd_key, e.e, e.v, e.k); else n_pass++;
            end
        end
        rd_en = 1'b0;
        start = 1'b0;
        n_chk++; if (i != NR + 1) $display("FAIL gen_length got=%0d exp=%0d", i, NR + 1); else n_pass++;
        n_chk++; if (ready !== 1'b1 || done !== 1'b1) $display("FAIL ready_done got=%0b%0b exp=11", ready, done); else n_pass++;
        bad = 0;
        for (int j = 0; j < caps.size() && j <= NR; j++) if (caps[j] !== exp_slot[j]) bad++;
        n_chk++; if (caps.size() != NR + 1 || bad != 0)
            $display("FAIL captures got=%0d(bad %0d) exp=%0d", caps.size(), bad, NR + 1); else n_pass++;
        caps.delete();
        tick;
        if (done === 1'b1) dones++;
        n_chk++; if (dones != 1 || ready !== 1'b1) $display("FAIL done_once got=%0d/%0b exp=1/1", dones, ready); else n_pass++;
    endtask

    task automatic test_known_vectors;
        logic [63:0] kv [3];
        kv[0] = 64'h0; kv[1] = 64'h00000001_00000001; kv[2] = 64'h01000002_01000003;
        for (int j = 0; j < 3; j++) begin
            rd_en = 1'b1; rd_idx = 4'(j);
            sb.push_back('{1'b1, 1'b0, kv[j]});
            tick;
            e = sb.pop_front();
            n_chk++; if (rd_valid !== e.v || rd_err !== e.e || rd_key !== e.k)
                $display("FAIL known_vec idx=%0d got=%0b%0b/%h exp=%0b%0b/%h", j, rd_valid, rd_err, rd_key, e.v, e.e, e.k); else n_pass++;
            last_key = kv[j];
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reads;
        int idxs[$] = '{0, 1, 2, 11, NR, 5, 15, 3, 7};
        foreach (idxs[j]) begin
            rd_en = 1'b1; rd_idx = 4'(idxs[j]);
            if (idxs[j] <= NR) begin
                sb.push_back('{1'b1, 1'b0, exp_slot[idxs[j]]});
                last_key = exp_slot[idxs[j]];
            end else begin
                sb.push_back('{1'b0, 1'b1, last_key});
            end
            tick;
            e = sb.pop_front();
            n_chk++; if (rd_valid !== e.v || rd_err !== e.e || rd_key !== e.k)
                $display("FAIL read idx=%0d got=%0b%0b/%h exp=%0b%0b/%h", idxs[j], rd_valid, rd_err, rd_key, e.v, e.e, e.k); else n_pass++;
        end
        rd_en = 1'b0;
        tick;
        n_chk++; if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_key !== last_key)
            $display("FAIL read_idle got=%0b%0b/%h exp=00/%h", rd_valid, rd_err, rd_key, last_key); else n_pass++;
    endtask

    task automatic test_reset_in_gen;
        cipher_key = 64'hDEADBEEF_12345678;
        start = 1'b1; tick; start = 1'b0;
        repeat (5) tick;
        n_chk++; if (busy !== 1'b1) $display("FAIL gen5_busy got=%0b exp=1", busy); else n_pass++;
        RST = 1'b1; start = 1'b1; rd_en = 1'b1; rd_idx = 4'd2;
        tick;
        n_chk++; if (busy !== 1'b0 || ready !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_state got=%0b%0b%0b exp=000", busy, ready, done); else n_pass++;
        n_chk++; if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_key !== 64'h0)
            $display("FAIL abort_read got=%0b%0b/%h exp=00/0", rd_valid, rd_err, rd_key); else n_pass++;
        n_chk++; if (kg_select !== 1'b0 || kg_enable_ !== 1'b1)
            $display("FAIL abort_kg got=%0b%0b exp=01", kg_select, kg_enable_); else n_pass++;
        tick;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_priority got=%0b exp=0", busy); else n_pass++;
        RST = 1'b0; rd_en = 1'b0;
        tick; start = 1'b0;
        n_chk++; if (busy !== 1'b1) $display("FAIL second_start got=%0b exp=1", busy); else n_pass++;
        tick; tick;
        RST = 1'b1; tick; RST = 1'b0;
        rd_en = 1'b1; rd_idx = 4'd1;
        tick;
        rd_en = 1'b0;
        n_chk++; if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_key !== 64'h0)
            $display("FAIL idle_read got=%0b%0b/%h exp=10/0", rd_err, rd_valid, rd_key); else n_pass++;
        last_key = 64'h0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_expand(64'h0, 1'b0, 1'b0, 1'b0);
        test_known_vectors;
        test_reads;
        test_expand(64'h01234567_89ABCDEF, 1'b1, 1'b1, 1'b0);
        test_reads;
        test_expand(64'hA5A5F00F_3C3C9669, 1'b0, 1'b0, 1'b1);
        test_reads;
        test_reset_in_gen;
        test_expand(64'h0F1E2D3C_4B5A6978, 1'b0, 1'b0, 1'b0);
        test_reads;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
